// File: rtl/npu_sched_pkg.sv
// Shared types and descriptor layout for the NPU job scheduler.
// A descriptor packs {ID, BIAS, CON_SIG, SSFR} into one FIFO word.
package npu_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_REPORT = 2'd3
  } sched_state_t;

  localparam int DESC_W   = 44;
  localparam int SSFR_OFF = 0;
  localparam int CON_OFF  = 16;
  localparam int BIAS_OFF = 32;
  localparam int ID_OFF   = 40;

  function automatic logic [DESC_W-1:0] pack_desc(
    input logic [15:0] ssfr,
    input logic [15:0] con,
    input logic [7:0]  bias,
    input logic [3:0]  id
  );
    logic [DESC_W-1:0] d;
    d = {DESC_W{1'b0}};
    d[SSFR_OFF +: 16] = ssfr;
    d[CON_OFF  +: 16] = con;
    d[BIAS_OFF +: 8]  = bias;
    d[ID_OFF   +: 4]  = id;
    return d;
  endfunction

endpackage

// File: rtl/npu_job_fifo.sv
// Synchronous descriptor FIFO with flush; full/empty/level are registered
// and the next occupancy is exported so the owner can register its own flags.
module npu_job_fifo
  import npu_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = DESC_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [$clog2(DEPTH):0]   o_level_nxt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_full;
  logic          r_empty;
  logic          w_do_push;
  logic          w_do_pop;
  logic [LW-1:0] w_level_nxt;

  assign w_do_push = i_push && !r_full && !i_flush;
  assign w_do_pop  = i_pop && !r_empty && !i_flush;

  always_comb begin
    w_level_nxt = r_level;
    if (i_flush) begin
      w_level_nxt = {LW{1'b0}};
    end else if (w_do_push && !w_do_pop) begin
      w_level_nxt = r_level + LW'(1);
    end else if (w_do_pop && !w_do_push) begin
      w_level_nxt = r_level - LW'(1);
    end else begin
      w_level_nxt = r_level;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {LW{1'b0}};
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (i_flush) begin
        r_wr_ptr <= {AW{1'b0}};
        r_rd_ptr <= {AW{1'b0}};
      end else begin
        if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LW'(DEPTH));
      r_empty <= (w_level_nxt == LW'(0));
    end
  end

  // Storage carries no reset; only entries between the pointers are ever read.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata     = r_mem[r_rd_ptr];
  assign o_full      = r_full;
  assign o_empty     = r_empty;
  assign o_level     = r_level;
  assign o_level_nxt = w_level_nxt;

endmodule

// File: rtl/npu_job_scheduler.sv
// Queues host job descriptors and runs them one at a time on the NPU core,
// holding configuration stable per run and reporting completion or timeout.
module npu_job_scheduler
  import npu_sched_pkg::*;
#(
  parameter int QDEPTH  = 4,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 11
) (
  input  logic                    CLKEXT,
  input  logic                    RST_GLO,
  input  logic                    JOB_VALID,
  output logic                    JOB_READY,
  input  logic [15:0]             JOB_SSFR,
  input  logic [15:0]             JOB_CON,
  input  logic [7:0]              JOB_BIAS,
  input  logic [3:0]              JOB_ID,
  input  logic                    ABORT,
  output logic                    NPU_START,
  output logic [15:0]             NPU_SSFR,
  output logic [15:0]             NPU_CON_SIG,
  output logic [7:0]              NPU_BIAS,
  input  logic                    NPU_BUSY,
  input  logic                    NPU_DONE,
  output logic                    CMP_VALID,
  output logic [3:0]              CMP_ID,
  output logic                    CMP_ERR,
  input  logic                    CMP_READY,
  output logic [$clog2(QDEPTH):0] Q_LEVEL,
  output logic                    IDLE,
  output logic [15:0]             JOBS_DONE,
  output logic [7:0]              ERR_CNT
);

  localparam int LW = $clog2(QDEPTH) + 1;

  sched_state_t      r_state;
  sched_state_t      w_state_raw;
  sched_state_t      w_state_nxt;
  logic              w_pop_raw;
  logic              w_pop;
  logic              w_fire_raw;
  logic              w_cmp_fire;
  logic              w_to_err;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic [LW-1:0]     w_level;
  logic [LW-1:0]     w_level_nxt;
  logic [DESC_W-1:0] w_head;
  logic [DESC_W-1:0] w_wdata;

  logic              r_npu_start;
  logic [15:0]       r_ssfr;
  logic [15:0]       r_con;
  logic [7:0]        r_bias;
  logic [3:0]        r_cur_id;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_cmp_valid;
  logic [3:0]        r_cmp_id;
  logic              r_cmp_err;
  logic [15:0]       r_jobs_done;
  logic [7:0]        r_err_cnt;
  logic              r_idle;
  logic              r_job_ready;

  // A push coinciding with ABORT is dropped along with the flushed queue.
  assign w_push  = JOB_VALID && !w_full && !ABORT;
  assign w_wdata = pack_desc(JOB_SSFR, JOB_CON, JOB_BIAS, JOB_ID);

  npu_job_fifo #(
    .DEPTH (QDEPTH),
    .W     (DESC_W)
  ) u_fifo (
    .i_clk       (CLKEXT),
    .i_rst       (RST_GLO),
    .i_flush     (ABORT),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_wdata     (w_wdata),
    .o_rdata     (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (w_level),
    .o_level_nxt (w_level_nxt)
  );

  // Next-state and per-cycle strobes; ABORT overrides below.
  always_comb begin
    w_state_raw = r_state;
    w_pop_raw   = 1'b0;
    w_fire_raw  = 1'b0;
    w_to_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && !NPU_BUSY) begin
          w_pop_raw   = 1'b1;
          w_state_raw = S_LAUNCH;
        end else begin
          w_state_raw = S_IDLE;
        end
      end
      S_LAUNCH: begin
        w_state_raw = S_WAIT;
      end
      S_WAIT: begin
        // DONE wins over a simultaneous expiry.
        if (NPU_DONE) begin
          w_state_raw = S_REPORT;
          w_to_err    = 1'b0;
        end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
          w_state_raw = S_REPORT;
          w_to_err    = 1'b1;
        end else begin
          w_state_raw = S_WAIT;
        end
      end
      S_REPORT: begin
        if (CMP_READY) begin
          w_fire_raw  = 1'b1;
          w_state_raw = S_IDLE;
        end else begin
          w_state_raw = S_REPORT;
        end
      end
      default: begin
        w_state_raw = S_IDLE;
      end
    endcase
  end

  assign w_state_nxt = ABORT ? S_IDLE : w_state_raw;
  assign w_pop       = w_pop_raw && !ABORT;
  assign w_cmp_fire  = w_fire_raw && !ABORT;

  // FSM state register.
  always_ff @(posedge CLKEXT) begin
    if (RST_GLO) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output, config, timeout and statistics registers, all decoded from next state.
  always_ff @(posedge CLKEXT) begin
    if (RST_GLO) begin
      r_npu_start <= 1'b0;
      r_ssfr      <= 16'h0000;
      r_con       <= 16'h0000;
      r_bias      <= 8'h00;
      r_cur_id    <= 4'h0;
      r_to_cnt    <= {TO_W{1'b0}};
      r_cmp_valid <= 1'b0;
      r_cmp_id    <= 4'h0;
      r_cmp_err   <= 1'b0;
      r_jobs_done <= 16'h0000;
      r_err_cnt   <= 8'h00;
      r_idle      <= 1'b1;
      r_job_ready <= 1'b1;
    end else begin
      r_npu_start <= (w_state_nxt == S_LAUNCH);
      if (w_pop) begin
        r_ssfr   <= w_head[SSFR_OFF +: 16];
        r_con    <= w_head[CON_OFF +: 16];
        r_bias   <= w_head[BIAS_OFF +: 8];
        r_cur_id <= w_head[ID_OFF +: 4];
      end
      case (r_state)
        S_LAUNCH: r_to_cnt <= {TO_W{1'b0}};
        S_WAIT:   r_to_cnt <= r_to_cnt + TO_W'(1);
        default:  r_to_cnt <= r_to_cnt;
      endcase
      r_cmp_valid <= (w_state_nxt == S_REPORT);
      if ((r_state == S_WAIT) && (w_state_nxt == S_REPORT)) begin
        r_cmp_id  <= r_cur_id;
        r_cmp_err <= w_to_err;
      end
      if (w_cmp_fire) begin
        r_jobs_done <= r_jobs_done + 16'd1;
        if (r_cmp_err && (r_err_cnt != 8'hFF)) begin
          r_err_cnt <= r_err_cnt + 8'd1;
        end
      end
      r_idle      <= (w_state_nxt == S_IDLE) && (w_level_nxt == LW'(0));
      r_job_ready <= (w_level_nxt != LW'(QDEPTH));
    end
  end

  assign JOB_READY   = r_job_ready;
  assign NPU_START   = r_npu_start;
  assign NPU_SSFR    = r_ssfr;
  assign NPU_CON_SIG = r_con;
  assign NPU_BIAS    = r_bias;
  assign CMP_VALID   = r_cmp_valid;
  assign CMP_ID      = r_cmp_id;
  assign CMP_ERR     = r_cmp_err;
  assign Q_LEVEL     = w_level;
  assign IDLE        = r_idle;
  assign JOBS_DONE   = r_jobs_done;
  assign ERR_CNT     = r_err_cnt;

endmodule

// File: tb/tb_npu_job_scheduler.sv
// Directed bench for npu_job_scheduler with a small reactive NPU model
// (BUSY from START+2, DONE at START+m_dly unless m_never).
module tb_npu_job_scheduler;

  logic        CLKEXT = 1'b0;
  logic        RST_GLO;
  logic        JOB_VALID;
  logic        JOB_READY;
  logic [15:0] JOB_SSFR;
  logic [15:0] JOB_CON;
  logic [7:0]  JOB_BIAS;
  logic [3:0]  JOB_ID;
  logic        ABORT;
  logic        NPU_START;
  logic [15:0] NPU_SSFR;
  logic [15:0] NPU_CON_SIG;
  logic [7:0]  NPU_BIAS;
  logic        NPU_BUSY;
  logic        NPU_DONE;
  logic        CMP_VALID;
  logic [3:0]  CMP_ID;
  logic        CMP_ERR;
  logic        CMP_READY;
  logic [2:0]  Q_LEVEL;
  logic        IDLE;
  logic [15:0] JOBS_DONE;
  logic [7:0]  ERR_CNT;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_cnt    = -1;
  int   m_dly    = 10;
  bit   m_never  = 1'b0;
  bit   m_force_busy = 1'b0;
  logic m_busy   = 1'b0;
  logic m_done   = 1'b0;
  int   exp_done = 0;
  int   n;
  int   cnt_bad;

  assign NPU_BUSY = m_force_busy | m_busy;
  assign NPU_DONE = m_done;

  always #5 CLKEXT = ~CLKEXT;

  npu_job_scheduler #(.QDEPTH(4), .TIMEOUT(16), .TO_W(11)) dut (
    .CLKEXT(CLKEXT), .RST_GLO(RST_GLO), .JOB_VALID(JOB_VALID), .JOB_READY(JOB_READY),
    .JOB_SSFR(JOB_SSFR), .JOB_CON(JOB_CON), .JOB_BIAS(JOB_BIAS), .JOB_ID(JOB_ID),
    .ABORT(ABORT), .NPU_START(NPU_START), .NPU_SSFR(NPU_SSFR), .NPU_CON_SIG(NPU_CON_SIG),
    .NPU_BIAS(NPU_BIAS), .NPU_BUSY(NPU_BUSY), .NPU_DONE(NPU_DONE), .CMP_VALID(CMP_VALID),
    .CMP_ID(CMP_ID), .CMP_ERR(CMP_ERR), .CMP_READY(CMP_READY), .Q_LEVEL(Q_LEVEL),
    .IDLE(IDLE), .JOBS_DONE(JOBS_DONE), .ERR_CNT(ERR_CNT)
  );

  // NPU model, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge CLKEXT);
      #1;
      m_done = 1'b0;
      if (NPU_START === 1'b1) m_cnt = 0;
      else if (m_cnt >= 0) m_cnt = m_cnt + 1;
      if (m_cnt >= 0 && !m_never && m_cnt == m_dly) begin
        m_done = 1'b1;
        m_cnt  = -1;
      end
      m_busy = (m_cnt >= 2) && (m_cnt < m_dly);
    end
  end

  task automatic tick;
    @(posedge CLKEXT);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_job(input logic [15:0] ssfr, input logic [15:0] con,
                          input logic [7:0] bias, input logic [3:0] id);
    JOB_SSFR  = ssfr;
    JOB_CON   = con;
    JOB_BIAS  = bias;
    JOB_ID    = id;
    JOB_VALID = 1'b1;
    tick();
    JOB_VALID = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int bound, output int cyc);
    cyc = 0;
    while (NPU_START !== 1'b1 && cyc < bound) begin
      tick();
      cyc++;
    end
    check_val(tag, NPU_START, 1);
  endtask

  task automatic wait_cmp(input string tag, input int bound, output int cyc);
    cyc = 0;
    while (CMP_VALID !== 1'b1 && cyc < bound) begin
      tick();
      cyc++;
    end
    check_val(tag, CMP_VALID, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_GLO = 1'b1; JOB_VALID = 1'b0; JOB_SSFR = 16'h0; JOB_CON = 16'h0;
    JOB_BIAS = 8'h0; JOB_ID = 4'h0; ABORT = 1'b0; CMP_READY = 1'b1;
    tick(); tick();
    RST_GLO = 1'b0;
    check_val("rst_ready", JOB_READY, 1);
    check_val("rst_idle", IDLE, 1);
    check_val("rst_level", Q_LEVEL, 0);
    check_val("rst_start", NPU_START, 0);
    check_val("rst_cmp", CMP_VALID, 0);
    check_val("rst_done", JOBS_DONE, 0);

    // Single job, normal completion.
    push_job(16'h00A5, 16'h1234, 8'h5A, 4'd3);
    check_val("t1_level", Q_LEVEL, 1);
    check_val("t1_start_early", NPU_START, 0);
    wait_start("t1_start", 5, n);
    check_val("t1_start_lat", n, 1);
    check_val("t1_ssfr", NPU_SSFR, 16'h00A5);
    check_val("t1_con", NPU_CON_SIG, 16'h1234);
    check_val("t1_bias", NPU_BIAS, 8'h5A);
    tick();
    check_val("t1_start_pulse", NPU_START, 0);
    wait_cmp("t1_cmp", 40, n);
    check_val("t1_cmp_lat", n, 10);
    check_val("t1_id", CMP_ID, 3);
    check_val("t1_err", CMP_ERR, 0);
    check_val("t1_ssfr_hold", NPU_SSFR, 16'h00A5);
    tick(); exp_done++;
    check_val("t1_jobs", JOBS_DONE, exp_done);

    // Five jobs into a depth-4 queue while NPU is busy.
    m_force_busy = 1'b1;
    for (int i = 0; i < 4; i++) push_job(16'h2000 + 16'(i), 16'h0, 8'h0, 4'(i));
    check_val("t2_full_ready", JOB_READY, 0);
    check_val("t2_full_level", Q_LEVEL, 4);
    JOB_SSFR = 16'h2004; JOB_ID = 4'd4; JOB_VALID = 1'b1;
    tick(); tick(); tick();
    check_val("t2_no_overwrite", Q_LEVEL, 4);
    check_val("t2_held_off", JOB_READY, 0);
    m_force_busy = 1'b0;
    n = 0;
    while (JOB_READY !== 1'b1 && n < 20) begin tick(); n++; end
    check_val("t2_ready_back", JOB_READY, 1);
    tick();
    JOB_VALID = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_cmp("t2_cmp", 40, n);
      check_val("t2_id", CMP_ID, k);
      check_val("t2_err", CMP_ERR, 0);
      check_val("t2_ssfr", NPU_SSFR, 16'h2000 + 16'(k));
      tick(); exp_done++;
    end
    check_val("t2_jobs", JOBS_DONE, exp_done);

    // Timeout with a second job queued behind.
    m_never = 1'b1;
    push_job(16'h0777, 16'h0, 8'h0, 4'd7);
    wait_start("t3_start", 5, n);
    push_job(16'h0888, 16'h0, 8'h0, 4'd8);
    wait_cmp("t3_cmp", 40, n);
    check_val("t3_lat", n + 1, 17);
    check_val("t3_id", CMP_ID, 7);
    check_val("t3_err", CMP_ERR, 1);
    m_never = 1'b0;
    tick(); exp_done++;
    check_val("t3_errcnt", ERR_CNT, 1);
    check_val("t3_jobs", JOBS_DONE, exp_done);
    wait_start("t3_next_start", 10, n);
    check_val("t3_next_ssfr", NPU_SSFR, 16'h0888);
    wait_cmp("t3_next_cmp", 40, n);
    check_val("t3_next_id", CMP_ID, 8);
    check_val("t3_next_err", CMP_ERR, 0);
    tick(); exp_done++;

    // Completion back-pressure with a job waiting.
    CMP_READY = 1'b0;
    push_job(16'h0999, 16'h0, 8'h0, 4'd9);
    push_job(16'h0AAA, 16'h0, 8'h0, 4'd10);
    wait_cmp("t4_cmp", 40, n);
    cnt_bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (CMP_VALID !== 1'b1 || CMP_ID !== 4'd9 || NPU_START !== 1'b0) cnt_bad++;
      tick();
    end
    check_val("t4_hold", cnt_bad, 0);
    check_val("t4_id", CMP_ID, 9);
    check_val("t4_level", Q_LEVEL, 1);
    CMP_READY = 1'b1;
    tick(); exp_done++;
    wait_start("t4_next_start", 5, n);
    check_val("t4_next_ssfr", NPU_SSFR, 16'h0AAA);
    wait_cmp("t4_next_cmp", 40, n);
    check_val("t4_next_id", CMP_ID, 10);
    tick(); exp_done++;
    check_val("t4_jobs", JOBS_DONE, exp_done);

    // ABORT in S_WAIT with three jobs queued; same-cycle push is dropped.
    for (int i = 1; i <= 4; i++) push_job(16'h3000 + 16'(i), 16'h0, 8'h0, 4'(i));
    check_val("t5_level_pre", Q_LEVEL, 3);
    ABORT = 1'b1;
    JOB_SSFR = 16'h3FFF; JOB_ID = 4'd15; JOB_VALID = 1'b1;
    tick();
    ABORT = 1'b0; JOB_VALID = 1'b0;
    check_val("t5_level", Q_LEVEL, 0);
    check_val("t5_idle", IDLE, 1);
    check_val("t5_cmp", CMP_VALID, 0);
    check_val("t5_ready", JOB_READY, 1);
    cnt_bad = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (CMP_VALID !== 1'b0 || NPU_START !== 1'b0) cnt_bad++;
    end
    check_val("t5_quiet", cnt_bad, 0);
    check_val("t5_jobs", JOBS_DONE, exp_done);
    m_force_busy = 1'b1;
    push_job(16'h0666, 16'h0, 8'h66, 4'd6);
    cnt_bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (NPU_START !== 1'b0) cnt_bad++;
      tick();
    end
    check_val("t5_wait_busy", cnt_bad, 0);
    m_force_busy = 1'b0;
    wait_start("t5_start", 5, n);
    check_val("t5_start_lat", n, 1);
    check_val("t5_ssfr", NPU_SSFR, 16'h0666);
    check_val("t5_bias", NPU_BIAS, 8'h66);
    wait_cmp("t5_cmp_new", 40, n);
    check_val("t5_id", CMP_ID, 6);
    tick(); exp_done++;
    check_val("t5_jobs_after", JOBS_DONE, exp_done);

    // Reset pulsed during S_LAUNCH.
    push_job(16'h0101, 16'h0, 8'h0, 4'd1);
    push_job(16'h0202, 16'h0, 8'h0, 4'd2);
    check_val("t6_launch", NPU_START, 1);
    RST_GLO = 1'b1;
    tick();
    RST_GLO = 1'b0;
    check_val("t6_start", NPU_START, 0);
    check_val("t6_level", Q_LEVEL, 0);
    check_val("t6_jobs", JOBS_DONE, 0);
    check_val("t6_ready", JOB_READY, 1);
    check_val("t6_idle", IDLE, 1);
    check_val("t6_errcnt", ERR_CNT, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
